mux_nto1_pipe: RTL and testbench
================================

Name: mux_nto1_pipe

Overview:
Parametrised N-to-1, WIDTH-bit multiplexer with a registered output stage, for use as a MIPS pipeline-boundary select. Typical use is the register-destination select (rt / rd / $ra) latched into the ID/EX register. It generalises the 2:1 5-bit select to any width and input count. It adds stall hold, flush, a valid bit, and out-of-range select detection.

Parameters:
WIDTH, 5, data width of each input and of the output
NUM_IN, 3, number of selectable inputs (2..16)
SEL_W, clog2(NUM_IN) with a minimum of 1, width of the select bus
RESET_VAL, 0, value driven on out_40 after reset, flush or an invalid select

Ports:
Clk_40  input  1  clock; all state changes on the rising edge
Reset_40  input  1  asynchronous, active-high reset
in_flat_40  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel_40  input  SEL_W  input index
valid_in_40  input  1  qualifies the current select/data
stall_40  input  1  hold the output register
flush_40  input  1  squash the output register
clear_err_40  input  1  clears the sticky select-error flag
comb_out_40  output  WIDTH  unregistered selected value (forwarding preview)
out_40  output  WIDTH  registered selected value
valid_out_40  output  1  registered valid
sel_err_40  output  1  sticky out-of-range select flag

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - out_40 = RESET_VAL, valid_out_40 = 0, sel_err_40 = 0.
  - comb_out_40 is not reset; it follows its inputs.
- comb_out_40 (combinational):
  - equals input[sel_40] when sel_40 < NUM_IN;
  - equals RESET_VAL when sel_40 >= NUM_IN.
- Register update priority on each rising edge: flush > stall > load.
  - flush_40=1: out_40 <= RESET_VAL, valid_out_40 <= 0. This applies regardless of stall_40.
  - stall_40=1 and flush_40=0: out_40 and valid_out_40 hold their values.
  - Otherwise (load): out_40 <= comb_out_40, valid_out_40 <= valid_in_40.
- Latency: 1 cycle from sel_40/in_flat_40 to out_40 on a load.
- Data is loaded even when valid_in_40=0; the valid bit only qualifies it.
- Invalid select (sel_40 >= NUM_IN):
  - Only possible when NUM_IN is not a power of two.
  - On a load, out_40 <= RESET_VAL and valid_out_40 <= valid_in_40.
  - sel_err_40 <= 1 if valid_in_40=1.
- sel_err_40 is sticky until a clock edge with clear_err_40=1.
  - If set and clear occur on the same edge, set wins and the flag stays 1.
  - An invalid select during stall or flush does not set the flag.
- NUM_IN a power of two: sel_err_40 is tied to 0.
- No internal counters or state beyond the out_40, valid_out_40 and sel_err_40 registers.
- No combinational path from stall_40 or flush_40 to any output.

Decomposition:
- Shared package mux_pkg:
  - clog2-style SEL_W function;
  - default constants REGDST_W=5 and REGDST_RA=5'd31;
  - localparam enum for regdst select: RT=0, RD=1, RA=2.
- One sub-module, mux_nto1_comb (WIDTH, NUM_IN): pure combinational index select with out-of-range default. It produces comb_out_40 and is reusable on its own.
- The top level holds the output register, the priority logic and the error flag.

Test Plan:
All scenarios use WIDTH=5 and NUM_IN=3, with in0=5'd20, in1=5'd11, in2=5'd31.
1. Reset check: assert Reset_40 mid-cycle after loading 5'd11 -> out_40=0, valid_out_40=0 and sel_err_40=0 immediately, without waiting for a clock edge.
2. Sequential selects: sel=0,1,2 on three consecutive cycles with valid_in=1 -> out_40 = 20, 11, 31, each one cycle after its select; comb_out_40 shows the same values with no delay; valid_out_40=1.
3. Stall hold: load sel=1, then stall_40=1 for 3 cycles while sel=2 -> out_40 stays 11 and valid_out_40 stays 1; after the stall is released, the next edge gives out_40=31.
4. Flush priority: flush_40=1 together with stall_40=1 while out_40=31 -> next edge out_40=0, valid_out_40=0.
5. Invalid select: sel=3 with valid_in=1 -> out_40=0 and sel_err_40=1, held for subsequent valid selects. Assert clear_err_40 together with another sel=3 -> flag stays 1. clear_err_40 alone -> flag becomes 0.
6. Invalid select, unqualified: sel=3 with valid_in=0 -> out_40=0, valid_out_40=0, sel_err_40 stays 0.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and select-width helper for pipeline-boundary muxes
package mux_pkg;

  localparam int REGDST_W = 5;
  localparam logic [REGDST_W-1:0] REGDST_RA = 5'd31;

  typedef enum logic [1:0] {
    RT = 2'd0,
    RD = 2'd1,
    RA = 2'd2
  } regdst_sel_e;

  // ceil(log2(n)) with a floor of 1 so a 2-input mux still gets a select bit
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// rtl/mux_nto1_comb.sv - combinational N-to-1 index select with out-of-range default
module mux_nto1_comb
  import mux_pkg::*;
#(
  parameter int               WIDTH     = REGDST_W,
  parameter int               NUM_IN    = 3,
  parameter int               SEL_W     = sel_width(NUM_IN),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        comb_out,
  output logic                    sel_ok
);

  always_comb begin
    comb_out = RESET_VAL;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        comb_out = in_flat[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// rtl/mux_nto1_pipe.sv - registered N-to-1 select with stall, flush, valid and sticky select error
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int               WIDTH     = REGDST_W,
  parameter int               NUM_IN    = 3,
  parameter int               SEL_W     = sel_width(NUM_IN),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    Clk_40,
  input  logic                    Reset_40,
  input  logic [NUM_IN*WIDTH-1:0] in_flat_40,
  input  logic [SEL_W-1:0]        sel_40,
  input  logic                    valid_in_40,
  input  logic                    stall_40,
  input  logic                    flush_40,
  input  logic                    clear_err_40,
  output logic [WIDTH-1:0]        comb_out_40,
  output logic [WIDTH-1:0]        out_40,
  output logic                    valid_out_40,
  output logic                    sel_err_40
);

  localparam bit IS_POW2 = ((NUM_IN & (NUM_IN - 1)) == 0);

  logic sel_ok;
  logic load;

  mux_nto1_comb #(
    .WIDTH    (WIDTH),
    .NUM_IN   (NUM_IN),
    .SEL_W    (SEL_W),
    .RESET_VAL(RESET_VAL)
  ) u_comb (
    .in_flat (in_flat_40),
    .sel     (sel_40),
    .comb_out(comb_out_40),
    .sel_ok  (sel_ok)
  );

  assign load = !flush_40 && !stall_40;

  always_ff @(posedge Clk_40 or posedge Reset_40) begin
    if (Reset_40) begin
      out_40       <= RESET_VAL;
      valid_out_40 <= 1'b0;
    end else if (flush_40) begin
      out_40       <= RESET_VAL;
      valid_out_40 <= 1'b0;
    end else if (load) begin
      out_40       <= comb_out_40;
      valid_out_40 <= valid_in_40;
    end
  end

  // Set beats clear on the same edge; a power-of-two mux can never go out of range
  always_ff @(posedge Clk_40 or posedge Reset_40) begin
    if (Reset_40) begin
      sel_err_40 <= 1'b0;
    end else if (!IS_POW2 && load && valid_in_40 && !sel_ok) begin
      sel_err_40 <= 1'b1;
    end else if (clear_err_40) begin
      sel_err_40 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb/tb_mux_nto1_pipe.sv - vector table plus randomized reference-model check of mux_nto1_pipe
module tb_mux_nto1_pipe;

  localparam int W = 5;
  localparam int N = 3;
  localparam int SW = 2;

  logic          clk;
  logic          rst;
  logic [N*W-1:0] in_flat;
  logic [SW-1:0] sel;
  logic          vin, stall, flush, clr;
  logic [W-1:0]  comb_out, out;
  logic          vout, err;

  int tests = 0;
  int fails = 0;

  mux_nto1_pipe #(
    .WIDTH    (W),
    .NUM_IN   (N),
    .SEL_W    (SW),
    .RESET_VAL(5'd0)
  ) dut (
    .Clk_40      (clk),
    .Reset_40    (rst),
    .in_flat_40  (in_flat),
    .sel_40      (sel),
    .valid_in_40 (vin),
    .stall_40    (stall),
    .flush_40    (flush),
    .clear_err_40(clr),
    .comb_out_40 (comb_out),
    .out_40      (out),
    .valid_out_40(vout),
    .sel_err_40  (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] sel;
    logic       vin, stall, flush, clr;
    logic [4:0] comb, out;
    logic       vout, err;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic v, input logic st,
                       input logic fl, input logic cl);
    sel = s; vin = v; stall = st; flush = fl; clr = cl;
  endtask

  // Reference model state: what the spec says the registers hold
  logic [W-1:0] m_in[N];
  logic [W-1:0] m_out, m_comb;
  logic         m_vout, m_err;

  initial begin
    // sel vin stall flush clr | comb out vout err
    tbl[0]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd20, 5'd20, 1'b1, 1'b0};
    tbl[1]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 5'd11, 1'b1, 1'b0};
    tbl[2]  = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 5'd11, 1'b1, 1'b0};
    tbl[4]  = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 5'd11, 1'b1, 1'b0};
    tbl[5]  = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 5'd11, 1'b1, 1'b0};
    tbl[6]  = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 5'd11, 1'b1, 1'b0};
    tbl[7]  = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 1'b1, 1'b0};
    tbl[8]  = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 5'd0,  1'b0, 1'b0};
    tbl[9]  = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1};
    tbl[10] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd20, 5'd20, 1'b1, 1'b1};
    tbl[11] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1};
    tbl[12] = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 5'd11, 1'b1, 1'b0};
    tbl[13] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0};
    tbl[14] = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0};
    tbl[15] = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0};
    tbl[16] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 1'b0, 1'b0};

    in_flat = {5'd31, 5'd11, 5'd20};
    rst = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_out", out, 0);
    check("reset_valid", vout, 0);
    check("reset_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mid-cycle asynchronous reset after a load of 11 with the error flag set
    drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset_err", err, 1);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset_out", out, 11);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", out, 0);
    check("async_reset_valid", vout, 0);
    check("async_reset_err", err, 0);
    check("reset_comb_follows", comb_out, 11);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].sel, tbl[i].vin, tbl[i].stall, tbl[i].flush, tbl[i].clr);
      #1;
      check($sformatf("vec%0d_comb", i), comb_out, tbl[i].comb);
      @(posedge clk); #1;
      check($sformatf("vec%0d_out", i), out, tbl[i].out);
      check($sformatf("vec%0d_valid", i), vout, tbl[i].vout);
      check($sformatf("vec%0d_err", i), err, tbl[i].err);
    end

    // Randomized run against a behavioural model, seeded from the table's final state
    m_out = 5'd31; m_vout = 1'b0; m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        m_in[k] = 5'($urandom_range(0, 31));
        in_flat[k*W +: W] = m_in[k];
      end
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) == 0));
      m_comb = (int'(sel) < N) ? m_in[sel] : 5'd0;
      #1;
      check($sformatf("rnd%0d_comb", c), comb_out, m_comb);
      if (flush) begin
        m_out = 5'd0; m_vout = 1'b0;
      end else if (!stall) begin
        m_out = m_comb; m_vout = vin;
      end
      if (!flush && !stall && vin && int'(sel) >= N) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      @(posedge clk); #1;
      check($sformatf("rnd%0d_out", c), out, m_out);
      check($sformatf("rnd%0d_valid", c), vout, m_vout);
      check($sformatf("rnd%0d_err", c), err, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
